// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding, per-stage payload widths
// and field-offset macros that callers use to pack and unpack the stage bus.
package cpu_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } buf_state_t;

  localparam int IDEX_W  = 118;
  localparam int EXMEM_W = 73;

endpackage

// ID/EX bus layout: {ctrl[21:0], imm[31:0], rs2[31:0], rs1[31:0]}
`define IDEX_RS1_LSB   0
`define IDEX_RS2_LSB   32
`define IDEX_IMM_LSB   64
`define IDEX_CTRL_LSB  96
// EX/MEM bus layout: {ctrl[8:0], store_data[31:0], alu_result[31:0]}
`define EXMEM_ALU_LSB  0
`define EXMEM_STD_LSB  32
`define EXMEM_CTRL_LSB 64

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: increments by one per cycle with inc high and sticks at all-ones.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and 2-entry skid buffer.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_buf: DATA_W and CNT_W must be >= 1");
  end

  buf_state_t        state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              push, pop;

  // in_ready depends only on registered state plus the bubble input.
  assign in_ready  = (state_reg != S_TWO) && !bubble;
  assign out_valid = (state_reg != S_EMPTY);
  assign out_data  = main_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = S_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      unique case (state_reg)
        S_EMPTY: begin
          if (push) begin
            state_next = S_ONE;
            main_next  = in_data;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_next = in_data;
          end else if (push) begin
            state_next = S_TWO;
            skid_next  = in_data;
          end else if (pop) begin
            state_next = S_EMPTY;
          end
        end
        S_TWO: begin
          // Skid entry slides forward; in_ready is low here so no push competes.
          if (pop) begin
            state_next = S_ONE;
            main_next  = skid_reg;
          end
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios then random traffic, all checked against
// a queue-based FIFO model (capacity 2) with flush/reset clearing.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, bubble, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

  pipe_stage_buf #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bubble    (bubble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic [31:0] resid = '0;
  int          m_stall = 0;
  int          m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    resid   = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One clock: drive inputs, check in_ready, clock, then compare against the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                       input logic bub, input logic fl, output logic accepted);
    logic exp_rdy, do_pop;
    in_valid = v; in_data = d; out_ready = ordy; bubble = bub; flush = fl;
    #1;
    exp_rdy  = (q.size() < 2) && !bub;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    accepted = v && exp_rdy;
    do_pop   = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy) m_stall = sat(m_stall + 1);
    if (fl) m_flush = sat(m_flush + 1);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      resid = '0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (accepted) q.push_back(d);
    end
    if (q.size() > 0) resid = q[0];
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("out_data", out_data, resid);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", {30'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {30'd0, flush_cnt}, m_flush);
`endif
    $display("t=%0t v=%b d=%0h ordy=%b bub=%b fl=%b -> ovalid=%b odata=%0h irdy=%b depth=%0d",
             $time, v, d, ordy, bub, fl, out_valid, out_data, in_ready, q.size());
  endtask

  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] pdata;

    rst = 1'b1; flush = 0; bubble = 0; in_valid = 0; out_ready = 0; in_data = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // 1: stream 1..8 at full rate
    for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // 2: backpressure mid-stream of A,B,C
    cycle(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_in_ready_two", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // 3: flush while full with D pending
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h12, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, acc);
    chk("flush_out_data", out_data, 32'd0);
    cycle(1'b1, 32'h13, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // 4: bubble for two cycles with E waiting
    cycle(1'b1, 32'hE, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hE, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hE, 1'b1, 1'b0, 1'b0, acc);
    chk("bubble_e_out", out_data, 32'hE);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // 5: async reset between edges while full
    cycle(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, acc);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 6: stall for 5 cycles then 2 flush cycles (counters checked inside cycle)
    cycle(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_sat", {30'd0, stall_cnt}, 32'd3);
    chk("flush_two", {30'd0, flush_cnt}, 32'd2);
`endif

    // Random traffic; pending input data held stable until accepted
    pend = 1'b0; pdata = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom_range(3) != 0)) begin
        pend  = 1'b1;
        pdata = $urandom;
      end
      cycle(pend, pdata, ($urandom_range(2) != 0), ($urandom_range(4) == 0),
            ($urandom_range(19) == 0), acc);
      if (acc || flush) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
